// File: rtl/alu_result_sender_pkg.sv
// Shared definitions for the ALU result sender: FSM state encoding and width helpers.
package alu_result_sender_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StWait = 2'b10
  } snd_state_e;

  function automatic int unsigned num_bytes(input int unsigned out_w, input int unsigned data_w);
    return out_w / data_w;
  endfunction

  // A one-byte result still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_result_sender.sv
// Serializes each captured ALU result LSB-first into the UART_TX parallel-load handshake,
// with a one-entry pending buffer for a result arriving mid-frame.
module alu_result_sender
  import alu_result_sender_pkg::*;
#(
  parameter int unsigned OUT_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  input  logic                  TX_BUSY,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  SND_BUSY,
  output logic                  DROP
);

  localparam int unsigned NUM_BYTES = num_bytes(OUT_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W     = cnt_width(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  snd_state_e            state_q, state_d;
  logic [OUT_WIDTH-1:0]  shift_q, shift_d, shift_nxt;
  logic [OUT_WIDTH-1:0]  pend_q, pend_d, load_val;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_vld_q, pend_vld_d;
  logic [DATA_WIDTH-1:0] tx_data_d;
  logic                  tx_vld_d, drop_d, snd_busy_d;
  logic                  frame_done, can_load, take_pend, take_new;

  assign shift_nxt  = shift_q >> DATA_WIDTH;
  assign frame_done = (state_q == StWait) && !TX_BUSY && (cnt_q == LAST_CNT);
  assign can_load   = (state_q == StIdle) || frame_done;
  // The older pending result always wins over a result arriving the same cycle.
  assign take_pend  = can_load && pend_vld_q;
  assign take_new   = can_load && !pend_vld_q && OUT_VALID;
  assign load_val   = take_pend ? pend_q : ALU_OUT;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    tx_vld_d  = TX_D_VLD;
    tx_data_d = TX_P_DATA;
    if (take_pend || take_new) begin
      state_d   = StLoad;
      shift_d   = load_val;
      cnt_d     = '0;
      tx_vld_d  = 1'b1;
      tx_data_d = load_val[DATA_WIDTH-1:0];
    end else begin
      unique case (state_q)
        StLoad: begin
          if (TX_BUSY) begin
            tx_vld_d = 1'b0;
            state_d  = StWait;
          end
        end
        StWait: begin
          if (!TX_BUSY) begin
            if (cnt_q != LAST_CNT) begin
              shift_d   = shift_nxt;
              cnt_d     = cnt_q + CNT_W'(1);
              tx_vld_d  = 1'b1;
              tx_data_d = shift_nxt[DATA_WIDTH-1:0];
              state_d   = StLoad;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pending entry: written when empty or when drained this cycle; otherwise the new result drops.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    drop_d     = 1'b0;
    if (take_pend) begin
      pend_vld_d = 1'b0;
    end
    if (OUT_VALID && !take_new) begin
      if (!pend_vld_q || take_pend) begin
        pend_d     = ALU_OUT;
        pend_vld_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  assign snd_busy_d = (state_d != StIdle) || pend_vld_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      TX_P_DATA  <= '0;
      TX_D_VLD   <= 1'b0;
      SND_BUSY   <= 1'b0;
      DROP       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      TX_P_DATA  <= tx_data_d;
      TX_D_VLD   <= tx_vld_d;
      SND_BUSY   <= snd_busy_d;
      DROP       <= drop_d;
    end
  end

endmodule

// File: tb/tb_alu_result_sender.sv
// Bench for alu_result_sender: a UART_TX handshake model plus a result-occupancy reference model.
module tb_alu_result_sender;

  localparam int unsigned OW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NB = OW / DW;

  logic          CLK = 1'b0;
  logic          RST;
  logic [OW-1:0] ALU_OUT;
  logic          OUT_VALID;
  logic          TX_BUSY;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          SND_BUSY;
  logic          DROP;

  int checks = 0;
  int errors = 0;

  // Reference model: results held by the sender (in flight + pending, at most 2) and byte stream.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_log[$];
  logic [DW-1:0] want_q[$];
  int occ;
  int bytes_rcv;
  // UART_TX model state.
  int accept_delay;
  int hold_len;
  int wait_left;
  int hold_left;
  bit armed;
  bit busy_drv;
  bit last_b;

  alu_result_sender #(
    .OUT_WIDTH (OW),
    .DATA_WIDTH(DW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ALU_OUT  (ALU_OUT),
    .OUT_VALID(OUT_VALID),
    .TX_BUSY  (TX_BUSY),
    .TX_P_DATA(TX_P_DATA),
    .TX_D_VLD (TX_D_VLD),
    .SND_BUSY (SND_BUSY),
    .DROP     (DROP)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ       = 0;
    bytes_rcv = 0;
    armed     = 1'b0;
    busy_drv  = 1'b0;
    last_b    = 1'b0;
    wait_left = 0;
    hold_left = 0;
  endtask

  // UART_TX: waits accept_delay cycles of TX_D_VLD, then takes the byte and stays busy hold_len.
  task automatic uart_step();
    if (busy_drv) begin
      hold_left--;
      if (hold_left == 0) busy_drv = 1'b0;
    end else if (TX_D_VLD) begin
      if (!armed) begin
        armed     = 1'b1;
        wait_left = accept_delay;
      end
      if (wait_left == 0) begin
        armed = 1'b0;
        if (exp_q.size() > 0) begin
          check("accepted_byte", TX_P_DATA, exp_q[0]);
          void'(exp_q.pop_front());
        end
        rx_log.push_back(TX_P_DATA);
        bytes_rcv++;
        hold_left = hold_len;
        busy_drv  = 1'b1;
      end else begin
        wait_left--;
      end
    end else if (armed) begin
      armed = 1'b0;
      check("vld_held_until_accept", TX_D_VLD, 1);
    end
  endtask

  task automatic step(input bit v, input logic [OW-1:0] d);
    bit retire;
    bit drop_exp;
    OUT_VALID = v;
    ALU_OUT   = d;
    TX_BUSY   = busy_drv;
    @(posedge CLK);
    // A result leaves the sender when busy falls after its last byte.
    retire = last_b && !busy_drv && (bytes_rcv > 0) && (bytes_rcv % NB == 0);
    if (retire) occ--;
    drop_exp = 1'b0;
    if (v) begin
      if (occ < 2) begin
        occ++;
        for (int i = 0; i < NB; i++) exp_q.push_back(d[i*DW +: DW]);
      end else begin
        drop_exp = 1'b1;
      end
    end
    last_b = busy_drv;
    #1;
    check("drop", DROP, drop_exp);
    check("snd_busy", SND_BUSY, occ > 0);
    if (TX_D_VLD) begin
      if (exp_q.size() == 0) check("vld_without_data", TX_D_VLD, 0);
      else check("tx_p_data", TX_P_DATA, exp_q[0]);
    end
    uart_step();
  endtask

  task automatic run_idle(input int n);
    repeat (n) step(1'b0, OW'($urandom));
  endtask

  task automatic drain(input int max);
    int k;
    k = 0;
    while ((occ > 0 || busy_drv) && k < max) begin
      step(1'b0, OW'($urandom));
      k++;
    end
    check("drain_bytes_left", exp_q.size(), 0);
    check("drain_snd_busy", SND_BUSY, 0);
  endtask

  task automatic wait_frame_end(input int max);
    int k;
    bit ok;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < max) begin
      ok = last_b && !busy_drv && (bytes_rcv > 0) && (bytes_rcv % NB == 0);
      if (!ok) step(1'b0, OW'($urandom));
      k++;
    end
    check("frame_end_reached", ok, 1);
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_count"}, rx_log.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < rx_log.size(); i++) check(tag, rx_log[i], want_q[i]);
    rx_log.delete();
  endtask

  initial begin
    RST          = 1'b0;
    OUT_VALID    = 1'b0;
    TX_BUSY      = 1'b0;
    ALU_OUT      = '0;
    accept_delay = 0;
    hold_len     = 10;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_vld", TX_D_VLD, 0);
    check("rst_data", TX_P_DATA, 0);
    check("rst_snd_busy", SND_BUSY, 0);
    check("rst_drop", DROP, 0);
    #3 RST = 1'b1;

    // Single result, one-cycle latency.
    step(1'b1, 16'hA55A);
    check("latency_vld", TX_D_VLD, 1);
    check("latency_byte", TX_P_DATA, 8'h5A);
    drain(300);
    want_q = '{8'h5A, 8'hA5};
    compare_log("single");

    // Slow accept: byte must stay presented while UART_TX holds off.
    accept_delay = 20;
    step(1'b1, 16'h1234);
    drain(300);
    accept_delay = 0;
    want_q = '{8'h34, 8'h12};
    compare_log("slow");

    // Back-to-back through the pending buffer.
    step(1'b1, 16'h1111);
    run_idle(5);
    step(1'b1, 16'h2222);
    drain(300);
    want_q = '{8'h11, 8'h11, 8'h22, 8'h22};
    compare_log("b2b");

    // Overflow: third result in one frame is dropped.
    step(1'b1, 16'h0001);
    run_idle(2);
    step(1'b1, 16'h0002);
    run_idle(2);
    step(1'b1, 16'h0003);
    check("overflow_drop", DROP, 1);
    drain(300);
    want_q = '{8'h01, 8'h00, 8'h02, 8'h00};
    compare_log("overflow");

    // Coincident: new result on the cycle the last byte completes.
    step(1'b1, 16'h00C3);
    wait_frame_end(300);
    step(1'b1, 16'hBEEF);
    check("coinc_drop", DROP, 0);
    check("coinc_vld", TX_D_VLD, 1);
    check("coinc_byte", TX_P_DATA, 8'hEF);
    drain(300);
    want_q = '{8'hC3, 8'h00, 8'hEF, 8'hBE};
    compare_log("coinc");

    // Reset asserted mid-LOAD clears outputs asynchronously.
    accept_delay = 50;
    step(1'b1, 16'h5678);
    run_idle(3);
    check("pre_rst_vld", TX_D_VLD, 1);
    #2 RST = 1'b0;
    #1;
    check("async_rst_vld", TX_D_VLD, 0);
    check("async_rst_snd_busy", SND_BUSY, 0);
    check("async_rst_drop", DROP, 0);
    model_reset();
    rx_log.delete();
    accept_delay = 0;
    OUT_VALID    = 1'b0;
    TX_BUSY      = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("held_rst_vld", TX_D_VLD, 0);
    #3 RST = 1'b1;
    run_idle(4);
    check("post_rst_vld", TX_D_VLD, 0);

    // Randomized traffic with varying UART_TX timing.
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) begin
        accept_delay = $urandom_range(0, 3);
        hold_len     = $urandom_range(1, 4);
      end
      step($urandom_range(0, 9) < 3, OW'($urandom));
    end
    drain(500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
